// File: rtl/uart_frame_monitor_if.sv
`timescale 1ns/1ps
// Report bus from one UART line monitor to its scoreboard/coverage consumer.
// Latency: n/a (signal bundle only).
// Backpressure: none; the consumer must accept every pulse as it happens.
interface uart_frame_monitor_if #(
    parameter int DATA_W_MAX = 9,
    parameter int CNT_W      = 16
);
    logic                  busy;
    logic                  frame_valid;
    logic [DATA_W_MAX-1:0] frame_data;
    logic                  err_glitch;
    logic                  err_parity;
    logic                  err_frame;
    logic                  err_break;
    logic [CNT_W-1:0]      frame_cnt;
    logic [CNT_W-1:0]      err_cnt;

    // Monitor side drives the report.
    modport master (
        output busy, frame_valid, frame_data,
        output err_glitch, err_parity, err_frame, err_break,
        output frame_cnt, err_cnt
    );

    // Consumer side only observes.
    modport slave (
        input busy, frame_valid, frame_data,
        input err_glitch, err_parity, err_frame, err_break,
        input frame_cnt, err_cnt
    );
endinterface

// File: rtl/uart_frame_monitor.sv
`timescale 1ns/1ps
// Passive UART line monitor: recovers data/parity/stop and flags glitch, parity, framing, break.
// Latency: frame report one cycle after the last mid-stop sample; glitch one cycle after mid-start.
// Backpressure: none; purely observational, report pulses are single-cycle and never stall.
module uart_frame_monitor #(
    parameter int OVERSAMPLE = 16,
    parameter int BR_W       = 8,
    parameter int DATA_W_MAX = 9,
    parameter int CNT_W      = 16
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic            uart_net,
    input  logic [3:0]      cfg_data_bits,
    input  logic            cfg_parity_en,
    input  logic            cfg_parity_odd,
    input  logic            cfg_stop2,
    input  logic [BR_W-1:0] cfg_br_div,
    input  logic            cnt_clr,
    uart_frame_monitor_if.master mon
);
    // cyc must hold bit_period-1 for the largest divider; PW adds a bit for the period itself.
    localparam int CYC_W = $clog2(OVERSAMPLE * (2 ** BR_W));
    localparam int PW    = CYC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_t;

    state_t           state;
    logic             rx_m, rx_s, rx_s_d;
    logic             fall;
    logic [CYC_W-1:0] cyc;
    logic [3:0]       bit_idx;
    logic             stop_idx;
    logic [DATA_W_MAX-1:0] data_sh;
    logic             all_low;
    logic             stop_low;
    logic             par_err;

    // Per-frame configuration captured at the start edge.
    logic [3:0]       nbits_q;
    logic             par_en_q, par_odd_q, stop2_q;
    logic [BR_W-1:0]  br_div_q;

    logic [3:0]       nbits_cfg;
    logic [PW-1:0]    period, per_m1, half_m1;
    logic             samp_half, samp_bit;
    logic             stop_low_nx, brk_nx;
    logic             err_evt;

    assign fall = rx_s_d & ~rx_s;

    assign period    = PW'(OVERSAMPLE) * (PW'(br_div_q) + PW'(1));
    assign per_m1    = period - PW'(1);
    assign half_m1   = (period >> 1) - PW'(1);
    assign samp_half = ({1'b0, cyc} == half_m1);
    assign samp_bit  = ({1'b0, cyc} == per_m1);

    // Stop-bit bookkeeping including the bit being sampled this cycle.
    assign stop_low_nx = stop_low | ~rx_s;
    assign brk_nx      = all_low & ~rx_s;

    // Clamp the requested data width into the supported 5..DATA_W_MAX range.
    always_comb begin
        nbits_cfg = cfg_data_bits;
        if (cfg_data_bits < 4'd5)
            nbits_cfg = 4'd5;
        else if (int'(cfg_data_bits) > DATA_W_MAX)
            nbits_cfg = 4'(DATA_W_MAX);
    end

    // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= uart_net;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    // Frame decoder FSM with registered busy/report outputs.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state           <= S_IDLE;
            cyc             <= '0;
            bit_idx         <= '0;
            stop_idx        <= 1'b0;
            data_sh         <= '0;
            all_low         <= 1'b0;
            stop_low        <= 1'b0;
            par_err         <= 1'b0;
            nbits_q         <= '0;
            par_en_q        <= 1'b0;
            par_odd_q       <= 1'b0;
            stop2_q         <= 1'b0;
            br_div_q        <= '0;
            mon.busy        <= 1'b0;
            mon.frame_valid <= 1'b0;
            mon.frame_data  <= '0;
            mon.err_glitch  <= 1'b0;
            mon.err_parity  <= 1'b0;
            mon.err_frame   <= 1'b0;
            mon.err_break   <= 1'b0;
        end else begin
            mon.frame_valid <= 1'b0;
            mon.err_glitch  <= 1'b0;
            mon.err_parity  <= 1'b0;
            mon.err_frame   <= 1'b0;
            mon.err_break   <= 1'b0;
            cyc             <= cyc + CYC_W'(1);
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state     <= S_START;
                        cyc       <= '0;
                        mon.busy  <= 1'b1;
                        nbits_q   <= nbits_cfg;
                        par_en_q  <= cfg_parity_en;
                        par_odd_q <= cfg_parity_odd;
                        stop2_q   <= cfg_stop2;
                        br_div_q  <= cfg_br_div;
                        data_sh   <= '0;
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        stop_low  <= 1'b0;
                        par_err   <= 1'b0;
                    end
                end
                S_START: begin
                    if (samp_half) begin
                        cyc <= '0;
                        if (rx_s) begin
                            mon.err_glitch <= 1'b1;
                            mon.busy       <= 1'b0;
                            state          <= S_IDLE;
                        end else begin
                            all_low <= 1'b1;
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (samp_bit) begin
                        cyc              <= '0;
                        data_sh[bit_idx] <= rx_s;
                        all_low          <= brk_nx;
                        if (bit_idx == nbits_q - 4'd1) begin
                            bit_idx <= '0;
                            state   <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (samp_bit) begin
                        cyc     <= '0;
                        par_err <= (((^data_sh) ^ rx_s) != par_odd_q);
                        all_low <= brk_nx;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (samp_bit) begin
                        cyc <= '0;
                        if (stop_idx == stop2_q) begin
                            // Leave mid-stop so a start edge half a bit later is caught.
                            mon.frame_valid <= 1'b1;
                            mon.frame_data  <= data_sh;
                            mon.err_break   <= brk_nx;
                            mon.err_frame   <= stop_low_nx & ~brk_nx;
                            mon.err_parity  <= par_err & ~brk_nx;
                            mon.busy        <= brk_nx;
                            state           <= brk_nx ? S_BRK_WAIT : S_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                            stop_low <= stop_low_nx;
                            all_low  <= brk_nx;
                        end
                    end
                end
                S_BRK_WAIT: begin
                    if (rx_s) begin
                        state    <= S_IDLE;
                        cyc      <= '0;
                        mon.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cyc      <= '0;
                    mon.busy <= 1'b0;
                end
            endcase
        end
    end

    // A glitch, or a frame carrying any error, counts once toward err_cnt.
    assign err_evt = mon.err_glitch |
                     (mon.frame_valid & (mon.err_parity | mon.err_frame | mon.err_break));

    // Saturating statistics counters fed by the registered report pulses; clear has priority.
    always_ff @(posedge pclk) begin
        if (preset || cnt_clr) begin
            mon.frame_cnt <= '0;
            mon.err_cnt   <= '0;
        end else begin
            if (mon.frame_valid && (mon.frame_cnt != '1))
                mon.frame_cnt <= mon.frame_cnt + CNT_W'(1);
            if (err_evt && (mon.err_cnt != '1))
                mon.err_cnt <= mon.err_cnt + CNT_W'(1);
        end
    end
endmodule
